neuron_input_loader: RTL and testbench
======================================

// Module: neuron_input_loader
// PURPOSE
//  Upstream feeder for the 8-input ReLU neuron. Accepts activations one byte
//  per cycle over a valid/ready stream and assembles them into an 8-lane
//  vector. Presents the vector in parallel (D_OUT lanes 0..7 -> neuron D0..D7)
//  with a valid/ready handshake. Double-buffered: shadow bank fills while the
//  output bank is held for the neuron.
// PARAMETERS
//  DW    8  activation width, bits
//  N_IN  8  lanes per vector; must be >= 2
// PORTS
//  CK        in   1            single clock, rising edge
//  RSTN      in   1            asynchronous active-low reset
//  IN_DATA   in   DW           activation byte
//  IN_VALID  in   1            IN_DATA valid
//  IN_LAST   in   1            final byte of this vector; qualified by IN_VALID
//  IN_READY  out  1            loader can accept a byte this cycle
//  D_OUT     out  N_IN x DW    packed lanes; lane i drives neuron Di
//  OUT_CNT   out  clog2(N_IN+1) number of real (non-padded) lanes in D_OUT
//  OUT_VALID out  1            D_OUT/OUT_CNT hold a complete vector
//  OUT_READY in   1            neuron consumes the vector this cycle
// BEHAVIOUR
//  Reset (RSTN low, async): state=FILL, wr_idx=0, shadow and D_OUT=0,
//   OUT_CNT=0, OUT_VALID=0. IN_READY is forced 0 while RSTN low.
//  Reset mid-operation discards any partial or held vector; no output pulse.
//  Handshakes: input accept = IN_VALID & IN_READY at a rising CK edge;
//   output consume = OUT_VALID & OUT_READY at a rising CK edge.
//  IN_READY = (state==FILL), combinational from state only; it never depends
//   on IN_VALID.
//  Once OUT_VALID is high, D_OUT and OUT_CNT remain stable until consumed.
//  FSM:
//   FILL: each accept writes IN_DATA to shadow[wr_idx], sets mask[wr_idx],
//    and increments wr_idx.
//    - Vector complete if (IN_LAST) or (wr_idx==N_IN-1) on the accepted byte.
//      On completion: go to HOLD; latch cnt=wr_idx+1.
//    - IN_LAST on a lane-0 byte gives a 1-lane vector.
//   HOLD: IN_READY=0. Output bank is free when (!OUT_VALID | OUT_READY), i.e.
//    a same-cycle consume frees it.
//    - If free at the edge: D_OUT[i] = mask[i] ? shadow[i] : 0 (zero-pad
//      short vectors so the ReLU sum is unaffected); OUT_CNT=cnt;
//      OUT_VALID=1; clear mask; wr_idx=0; go to FILL.
//    - Otherwise stay in HOLD.
//  Output bank: OUT_VALID clears on a consume edge unless a transfer lands
//   in the same edge, in which case it stays 1 with the new data.
//  Latency: final byte accepted at edge t -> OUT_VALID high after edge t+1
//   if the output bank is free. Sustained throughput is 1 vector per N_IN+1
//   cycles with OUT_READY held high.
//  Width rules: wr_idx is clog2(N_IN) bits and never wraps past N_IN-1, since
//   the full-lane condition forces HOLD. IN_DATA is stored unmodified (no
//   sign handling; activations are unsigned).
//  IN_LAST with IN_VALID low is ignored. IN_DATA/IN_LAST are don't-care
//   while IN_READY=0.
// STRUCTURE
//  dneuron_pkg holds: DW, N_IN defaults; typedef logic [DW-1:0] act_t;
//   typedef act_t [N_IN-1:0] act_vec_t; loader state enum {FILL, HOLD}.
//  No sub-module. One always_ff for FSM, counters and banks; one always_comb
//   for IN_READY and the free/complete terms.
// TESTING
//  1 Full vector: send bytes 1..8 with IN_VALID=1 and OUT_READY=1 ->
//    D_OUT=={8,7,..,1} (lane0=1), OUT_CNT=8, OUT_VALID a 1-cycle pulse 2
//    edges after byte 8; IN_READY low for exactly 1 cycle.
//  2 Short vector: bytes 0x10,0x20,0x30 with IN_LAST on 0x30 ->
//    lanes0-2 = 10,20,30 and lanes3-7 = 0; OUT_CNT=3.
//  3 Backpressure: OUT_READY=0, stream 2 full vectors -> first presented and
//    stable; second waits in HOLD with IN_READY=0. OUT_READY=1 for 1 cycle ->
//    second vector presented at the same edge; OUT_VALID stays 1.
//  4 Input gaps: IN_VALID toggled 1/0 randomly over 8 bytes -> vector
//    identical to scenario 1; no byte lost or duplicated.
//  5 Reset mid-fill: after 5 bytes, pulse RSTN low between edges ->
//    all outputs 0 immediately. Next 8 bytes (0xA0..0xA7) form a clean
//    vector with OUT_CNT=8 and no residue.
//  6 Single-lane: first byte 0xFF with IN_LAST -> lane0=FF, others 0, OUT_CNT=1.

Source files
------------

// File: rtl/dneuron_pkg.sv
// Shared types and defaults for the neuron datapath feeders.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dneuron_pkg;

  localparam int DW   = 8;
  localparam int N_IN = 8;

  typedef logic [DW-1:0]   act_t;
  typedef act_t [N_IN-1:0] act_vec_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

endpackage

// File: rtl/neuron_input_loader.sv
// Byte-stream to N_IN-lane vector assembler feeding the ReLU neuron, double-buffered.
// Latency: last byte accepted at edge t -> OUT_VALID after edge t+1 when the output bank is free.
// Backpressure: IN_READY drops while a completed vector waits for the output bank to free.
module neuron_input_loader #(
  parameter int DW   = dneuron_pkg::DW,
  parameter int N_IN = dneuron_pkg::N_IN
) (
  input  logic                     CK,
  input  logic                     RSTN,
  input  logic [DW-1:0]            IN_DATA,
  input  logic                     IN_VALID,
  input  logic                     IN_LAST,
  output logic                     IN_READY,
  output logic [N_IN-1:0][DW-1:0]  D_OUT,
  output logic [$clog2(N_IN+1)-1:0] OUT_CNT,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY
);

  import dneuron_pkg::*;

  localparam int IW = $clog2(N_IN);
  localparam int CW = $clog2(N_IN + 1);

  loader_state_t             state;
  logic [IW-1:0]             wr_idx;
  logic [CW-1:0]             cnt;
  logic [N_IN-1:0]           mask;
  logic [N_IN-1:0][DW-1:0]   shadow;

  logic accept;
  logic complete;
  logic out_free;

  // Input ready follows state only; also held low while reset is asserted.
  always_comb begin
    IN_READY = RSTN && (state == FILL);
    accept   = IN_VALID && IN_READY;
    complete = accept && (IN_LAST || (wr_idx == IW'(N_IN - 1)));
    out_free = !OUT_VALID || OUT_READY;
  end

  // Fill the shadow bank, then move it to the output bank once the neuron has taken the previous vector.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= FILL;
      wr_idx    <= '0;
      cnt       <= '0;
      mask      <= '0;
      shadow    <= '0;
      D_OUT     <= '0;
      OUT_CNT   <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      // A consume empties the output bank; a transfer below may refill it on the same edge.
      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      case (state)
        FILL: begin
          if (accept) begin
            shadow[wr_idx] <= IN_DATA;
            mask[wr_idx]   <= 1'b1;
            if (complete) begin
              // wr_idx is left in place; it is rewound on the transfer so it never wraps.
              cnt   <= CW'(wr_idx) + CW'(1);
              state <= HOLD;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (out_free) begin
            // Unwritten lanes are zeroed so a short vector adds nothing to the neuron sum.
            for (int i = 0; i < N_IN; i++) begin
              D_OUT[i] <= mask[i] ? shadow[i] : '0;
            end
            OUT_CNT   <= cnt;
            OUT_VALID <= 1'b1;
            mask      <= '0;
            wr_idx    <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_input_loader.sv
module tb_neuron_input_loader;

  localparam int DW = 8;
  localparam int N  = 8;

  logic                 CK = 1'b0;
  logic                 RSTN;
  logic [DW-1:0]        IN_DATA;
  logic                 IN_VALID;
  logic                 IN_LAST;
  logic                 IN_READY;
  logic [N-1:0][DW-1:0] D_OUT;
  logic [3:0]           OUT_CNT;
  logic                 OUT_VALID;
  logic                 OUT_READY;

  int total    = 0;
  int bad      = 0;
  int timeouts = 0;
  int stab_err = 0;
  int cyc      = 0;
  bit rand_rdy = 1'b0;

  logic [63:0] got_vec[$];
  logic [3:0]  got_cnt[$];
  int          got_cyc[$];

  logic        prev_vld  = 1'b0;
  logic        prev_cons = 1'b0;
  logic [63:0] prev_vec;
  logic [3:0]  prev_cnt;

  neuron_input_loader dut (
    .CK        (CK),
    .RSTN      (RSTN),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_LAST   (IN_LAST),
    .IN_READY  (IN_READY),
    .D_OUT     (D_OUT),
    .OUT_CNT   (OUT_CNT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  always #5 CK = ~CK;

  always @(posedge CK) cyc++;

  // Random consumer readiness when enabled.
  always @(negedge CK) if (rand_rdy) OUT_READY = 1'($urandom_range(0, 1));

  always @(negedge RSTN) prev_vld = 1'b0;

  // Monitor: samples 1 time unit before each rising edge; records consumed vectors
  // and flags any change of a presented but unconsumed vector.
  always begin
    @(negedge CK);
    #4;
    if (RSTN !== 1'b1) begin
      prev_vld = 1'b0;
    end else begin
      if (prev_vld && !prev_cons &&
          (OUT_VALID !== 1'b1 || D_OUT !== prev_vec || OUT_CNT !== prev_cnt))
        stab_err++;
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        got_vec.push_back(D_OUT);
        got_cnt.push_back(OUT_CNT);
        got_cyc.push_back(cyc);
      end
      prev_vld  = (OUT_VALID === 1'b1);
      prev_cons = (OUT_READY === 1'b1);
      prev_vec  = D_OUT;
      prev_cnt  = OUT_CNT;
    end
  end

  // Reference: first len bytes in lanes 0.., all higher lanes zero.
  function automatic logic [63:0] pad(input logic [63:0] b, input int len);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[i*8 +: 8] = b[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rand_bytes();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic clear_got();
    got_vec.delete();
    got_cnt.delete();
    got_cyc.delete();
  endtask

  // Offer one byte; returns at the falling edge just before the accepting rising edge.
  task automatic send_byte(input logic [7:0] d, input bit last, input int gap_pct);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge CK);
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        IN_VALID = 1'b0;
        IN_DATA  = 8'($urandom);
        IN_LAST  = 1'($urandom);
      end else begin
        IN_VALID = 1'b1;
        IN_DATA  = d;
        IN_LAST  = last;
        if (IN_READY === 1'b1) done = 1'b1;
      end
      n++;
      if (!done && n > 400) begin
        timeouts++;
        $display("FAIL send_byte timeout: byte %02h never accepted", d);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_vec(input logic [63:0] b, input int len, input bit last_full, input int gap);
    for (int i = 0; i < len; i++)
      send_byte(b[i*8 +: 8], (i == len - 1) && (len < N || last_full), gap);
  endtask

  task automatic idle();
    @(negedge CK);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    int k;
    k = 0;
    while (got_vec.size() < n && k < budget) begin
      @(negedge CK);
      k++;
    end
    if (got_vec.size() < n) begin
      timeouts++;
      $display("FAIL wait_got timeout: have %0d vectors, need %0d", got_vec.size(), n);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
    #1;
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    total++; if (OUT_CNT !== 4'd0) begin bad++; $display("FAIL reset_out_cnt got %0d want 0", OUT_CNT); end
    total++; if (D_OUT !== 64'h0) begin bad++; $display("FAIL reset_d_out got %h want 0", D_OUT); end
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", IN_READY); end
    repeat (2) @(negedge CK);
    #2 RSTN = 1'b1;
    #1;
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got %b want 1", IN_READY); end
  endtask

  task automatic test_full_vector();
    clear_got();
    OUT_READY = 1'b1;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 0);
    idle();
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL full_vld_t0 got %b want 0", OUT_VALID); end
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL full_rdy_hold got %b want 0", IN_READY); end
    @(negedge CK);
    total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL full_vld_t1 got %b want 1", OUT_VALID); end
    total++; if (D_OUT !== 64'h0807060504030201) begin bad++; $display("FAIL full_d_out got %h want 0807060504030201", D_OUT); end
    total++; if (OUT_CNT !== 4'd8) begin bad++; $display("FAIL full_cnt got %0d want 8", OUT_CNT); end
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL full_rdy_back got %b want 1", IN_READY); end
    @(negedge CK);
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL full_vld_t2 got %b want 0", OUT_VALID); end
    total++; if (got_vec.size() != 1) begin bad++; $display("FAIL full_count got %0d want 1", got_vec.size()); end
  endtask

  task automatic test_short_vector();
    clear_got();
    OUT_READY = 1'b1;
    send_vec(64'h302010, 3, 1'b1, 0);
    idle();
    wait_got(1, 50);
    total++; if (got_vec.size() < 1 || got_vec[0] !== 64'h302010) begin bad++; $display("FAIL short_vec got %h want 0000000000302010", got_vec.size() ? got_vec[0] : 64'hx); end
    total++; if (got_vec.size() < 1 || got_cnt[0] !== 4'd3) begin bad++; $display("FAIL short_cnt got %0d want 3", got_vec.size() ? got_cnt[0] : 4'hx); end
  endtask

  task automatic test_backpressure();
    logic [63:0] v1, v2;
    clear_got();
    OUT_READY = 1'b0;
    v1 = rand_bytes();
    v2 = rand_bytes();
    send_vec(v1, 8, 1'b0, 0);
    send_vec(v2, 8, 1'b1, 0);
    idle();
    repeat (3) @(negedge CK);
    total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL bp_vld got %b want 1", OUT_VALID); end
    total++; if (D_OUT !== v1) begin bad++; $display("FAIL bp_first got %h want %h", D_OUT, v1); end
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL bp_in_ready got %b want 0", IN_READY); end
    OUT_READY = 1'b1;
    @(negedge CK);
    OUT_READY = 1'b0;
    total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL bp_vld_swap got %b want 1", OUT_VALID); end
    total++; if (D_OUT !== v2) begin bad++; $display("FAIL bp_second got %h want %h", D_OUT, v2); end
    total++; if (OUT_CNT !== 4'd8) begin bad++; $display("FAIL bp_cnt got %0d want 8", OUT_CNT); end
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL bp_in_ready_free got %b want 1", IN_READY); end
    repeat (2) @(negedge CK);
    OUT_READY = 1'b1;
    wait_got(2, 20);
    total++; if (got_vec.size() != 2 || got_vec[0] !== v1 || got_vec[1] !== v2) begin bad++; $display("FAIL bp_order got %0d vectors want 2 in order", got_vec.size()); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
  endtask

  task automatic test_input_gaps();
    clear_got();
    OUT_READY = 1'b1;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 50);
    idle();
    wait_got(1, 50);
    repeat (3) @(negedge CK);
    total++; if (got_vec.size() != 1 || got_vec[0] !== 64'h0807060504030201) begin bad++; $display("FAIL gaps_vec got %0d vectors first %h want 1 of 0807060504030201", got_vec.size(), got_vec.size() ? got_vec[0] : 64'hx); end
    total++; if (got_vec.size() < 1 || got_cnt[0] !== 4'd8) begin bad++; $display("FAIL gaps_cnt got %0d want 8", got_vec.size() ? got_cnt[0] : 4'hx); end
  endtask

  task automatic test_reset_mid_fill();
    OUT_READY = 1'b0;
    send_vec(rand_bytes(), 8, 1'b0, 0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 0);
    @(negedge CK);
    IN_VALID = 1'b0;
    #2 RSTN = 1'b0;
    #1;
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_mid_vld got %b want 0", OUT_VALID); end
    total++; if (D_OUT !== 64'h0) begin bad++; $display("FAIL rst_mid_d_out got %h want 0", D_OUT); end
    total++; if (OUT_CNT !== 4'd0) begin bad++; $display("FAIL rst_mid_cnt got %0d want 0", OUT_CNT); end
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL rst_mid_in_ready got %b want 0", IN_READY); end
    #1 RSTN = 1'b1;
    clear_got();
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), 1'b0, 0);
    idle();
    wait_got(1, 50);
    repeat (5) @(negedge CK);
    total++; if (got_vec.size() != 1 || got_vec[0] !== 64'hA7A6A5A4A3A2A1A0) begin bad++; $display("FAIL rst_mid_vec got %0d vectors first %h want 1 of a7a6a5a4a3a2a1a0", got_vec.size(), got_vec.size() ? got_vec[0] : 64'hx); end
    total++; if (got_vec.size() < 1 || got_cnt[0] !== 4'd8) begin bad++; $display("FAIL rst_mid_cnt8 got %0d want 8", got_vec.size() ? got_cnt[0] : 4'hx); end
  endtask

  task automatic test_single_lane();
    clear_got();
    OUT_READY = 1'b1;
    send_byte(8'hFF, 1'b1, 0);
    idle();
    wait_got(1, 20);
    total++; if (got_vec.size() < 1 || got_vec[0] !== 64'hFF) begin bad++; $display("FAIL single_vec got %h want 00000000000000ff", got_vec.size() ? got_vec[0] : 64'hx); end
    total++; if (got_vec.size() < 1 || got_cnt[0] !== 4'd1) begin bad++; $display("FAIL single_cnt got %0d want 1", got_vec.size() ? got_cnt[0] : 4'hx); end
  endtask

  task automatic test_throughput();
    clear_got();
    OUT_READY = 1'b1;
    for (int v = 0; v < 3; v++) send_vec(rand_bytes(), 8, 1'b0, 0);
    idle();
    wait_got(3, 60);
    total++; if (got_vec.size() != 3 || got_cyc[2] - got_cyc[1] != N + 1) begin bad++; $display("FAIL throughput got spacing %0d want %0d", got_vec.size() == 3 ? got_cyc[2] - got_cyc[1] : -1, N + 1); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_vec[$];
    logic [3:0]  exp_cnt[$];
    logic [63:0] b;
    int len;
    clear_got();
    stab_err = 0;
    rand_rdy = 1'b1;
    for (int v = 0; v < 25; v++) begin
      b   = rand_bytes();
      len = $urandom_range(1, 8);
      exp_vec.push_back(pad(b, len));
      exp_cnt.push_back(4'(len));
      send_vec(b, len, 1'($urandom), $urandom_range(0, 1) ? 30 : 0);
    end
    idle();
    wait_got(25, 3000);
    rand_rdy  = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) @(negedge CK);
    total++; if (got_vec.size() != 25) begin bad++; $display("FAIL b2b_count got %0d want 25", got_vec.size()); end
    for (int i = 0; i < 25 && i < got_vec.size(); i++) begin
      total++;
      if (got_vec[i] !== exp_vec[i] || got_cnt[i] !== exp_cnt[i]) begin
        bad++;
        $display("FAIL b2b_vec[%0d] got %h/%0d want %h/%0d", i, got_vec[i], got_cnt[i], exp_vec[i], exp_cnt[i]);
      end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL b2b_stable got %0d changes want 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_short_vector();
    test_backpressure();
    test_input_gaps();
    test_reset_mid_fill();
    test_single_lane();
    test_throughput();
    test_back_to_back();
    total++; if (timeouts != 0) begin bad++; $display("FAIL timeouts got %0d want 0", timeouts); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
